snoop_cache_ctrl_mb: RTL and testbench

//  Generalised ACE snoop controller for the std data cache: accepts AC snoops, looks up all ways,

---
 rtl/snoop_cache_ctrl_mb.sv | 255 +++++++++++++++++++++++++
 tb/tb_snoop_cache_ctrl_mb.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_cache_ctrl_mb.sv
// ACE snoop controller for the data cache: accepts AC snoops, looks up all
// ways through the tag/data SRAM arbiter, updates line state and answers with
// a CR response followed (when data moves) by a multi-beat CD line.
module snoop_cache_ctrl_mb #(
    parameter int unsigned NR_WAYS = 4,
    parameter int unsigned INDEX_W = 12,
    parameter int unsigned TAG_W   = 44,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned CD_W    = 64,
    localparam int unsigned ADDR_W = INDEX_W + TAG_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      bypass_i,
    output logic                      busy_o,
    input  logic                      ac_valid_i,
    output logic                      ac_ready_o,
    input  logic [ADDR_W-1:0]         ac_addr_i,
    input  logic [3:0]                ac_snoop_i,
    output logic                      cr_valid_o,
    input  logic                      cr_ready_i,
    output logic [4:0]                cr_resp_o,
    output logic                      cd_valid_o,
    input  logic                      cd_ready_i,
    output logic [CD_W-1:0]           cd_data_o,
    output logic                      cd_last_o,
    output logic [NR_WAYS-1:0]        req_o,
    output logic [INDEX_W-1:0]        addr_o,
    output logic [TAG_W-1:0]          tag_o,
    input  logic                      gnt_i,
    output logic                      we_o,
    output logic [NR_WAYS-1:0]        vldrty_be_o,
    output logic                      wr_valid_o,
    output logic                      wr_dirty_o,
    output logic                      wr_shared_o,
    input  logic [NR_WAYS*LINE_W-1:0] data_i,
    input  logic [NR_WAYS-1:0]        hit_way_i,
    input  logic [NR_WAYS-1:0]        dirty_way_i,
    input  logic [NR_WAYS-1:0]        shared_way_i,
    output logic                      inv_o,
    output logic [ADDR_W-1:0]         inv_addr_o
);

    localparam int unsigned BEATS  = LINE_W / CD_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (BEATS < 1 || BEATS * CD_W != LINE_W) begin : g_bad_beats
        $error("LINE_W must be a positive integral multiple of CD_W");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_EVAL, S_UPDATE, S_CR, S_CD
    } state_e;

    typedef enum logic [3:0] {
        RD_ONCE       = 4'b0000,
        RD_SHARED     = 4'b0001,
        RD_CLEAN      = 4'b0010,
        RD_NSD        = 4'b0011,
        RD_UNIQUE     = 4'b0111,
        CLEAN_SHARED  = 4'b1000,
        CLEAN_INVALID = 4'b1001,
        MAKE_INVALID  = 4'b1101
    } snoop_e;

    state_e                        state_q, state_d;
    logic [ADDR_W-1:0]             addr_q;
    logic [3:0]                    snoop_q;
    logic [4:0]                    resp_q;
    logic [BEATS-1:0][CD_W-1:0]    line_q;
    logic [NR_WAYS-1:0]            hit_way_q;
    logic                          wr_valid_q, wr_dirty_q, wr_shared_q, inv_q;
    logic [BEAT_W-1:0]             beat_q;

    logic                          ac_supported;
    logic [NR_WAYS-1:0]            sel_way;
    logic                          sel_hit, sel_dirty, sel_shared;
    logic [BEATS-1:0][CD_W-1:0]    sel_line;
    logic                          ev_data, ev_pass_dirty, ev_is_shared, ev_upd, ev_inv, ev_shared;
    logic [4:0]                    ev_resp;

    assign ac_supported = ac_snoop_i inside {RD_ONCE, RD_SHARED, RD_CLEAN, RD_NSD, RD_UNIQUE,
                                             CLEAN_SHARED, CLEAN_INVALID, MAKE_INVALID};

    // Pick the lowest-index hit way and its flags/data for the evaluation cycle.
    always_comb begin
        sel_way    = '0;
        sel_hit    = 1'b0;
        sel_dirty  = 1'b0;
        sel_shared = 1'b0;
        sel_line   = '0;
        for (int w = NR_WAYS - 1; w >= 0; w--) begin
            if (hit_way_i[w]) begin
                sel_way    = '0;
                sel_way[w] = 1'b1;
                sel_hit    = 1'b1;
                sel_dirty  = dirty_way_i[w];
                sel_shared = shared_way_i[w];
                sel_line   = data_i[w*LINE_W +: LINE_W];
            end
        end
    end

    // Decode the snoop action for a hit: response bits and the state update to perform.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        ev_data       = 1'b0;
        ev_pass_dirty = 1'b0;
        ev_is_shared  = 1'b0;
        ev_upd        = 1'b0;
        ev_inv        = 1'b0;
        ev_shared     = sel_shared;
        case (snoop_q)
            RD_ONCE: begin
                ev_data      = 1'b1;
                ev_is_shared = 1'b1;
            end
            RD_SHARED, RD_CLEAN, RD_NSD: begin
                ev_data       = 1'b1;
                ev_pass_dirty = sel_dirty;
                ev_is_shared  = 1'b1;
                ev_upd        = 1'b1;
                ev_shared     = 1'b1;
            end
            RD_UNIQUE: begin
                ev_data       = 1'b1;
                ev_pass_dirty = sel_dirty;
                ev_upd        = 1'b1;
                ev_inv        = 1'b1;
            end
            CLEAN_SHARED: begin
                ev_data       = sel_dirty;
                ev_pass_dirty = sel_dirty;
                ev_is_shared  = 1'b1;
                ev_upd        = sel_dirty;
            end
            CLEAN_INVALID: begin
                ev_data       = sel_dirty;
                ev_pass_dirty = sel_dirty;
                ev_upd        = 1'b1;
                ev_inv        = 1'b1;
            end
            MAKE_INVALID: begin
                ev_upd = 1'b1;
                ev_inv = 1'b1;
            end
            default: ;
        endcase
        if (!sel_hit) begin
            ev_upd = 1'b0;
            ev_inv = 1'b0;
        end
        ev_resp = sel_hit ? {~sel_shared, ev_is_shared, ev_pass_dirty, 1'b0, ev_data} : 5'b0;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and handshake/SRAM control outputs.
    always_comb begin
        state_d     = state_q;
        ac_ready_o  = 1'b0;
        cr_valid_o  = 1'b0;
        cd_valid_o  = 1'b0;
        req_o       = '0;
        we_o        = 1'b0;
        vldrty_be_o = '0;
        inv_o       = 1'b0;
        case (state_q)
            S_IDLE: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) state_d = (bypass_i || !ac_supported) ? S_CR : S_LOOKUP;
            end
            S_LOOKUP: begin
                req_o = '1;
                if (gnt_i) state_d = S_EVAL;
            end
            S_EVAL: state_d = ev_upd ? S_UPDATE : S_CR;
            S_UPDATE: begin
                req_o       = hit_way_q;
                we_o        = 1'b1;
                vldrty_be_o = hit_way_q;
                if (gnt_i) begin
                    inv_o   = inv_q;
                    state_d = S_CR;
                end
            end
            S_CR: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) state_d = resp_q[0] ? S_CD : S_IDLE;
            end
            S_CD: begin
                cd_valid_o = 1'b1;
                if (cd_ready_i && beat_q == LAST_BEAT) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latched snoop context, evaluation results and CD beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            snoop_q     <= '0;
            resp_q      <= '0;
            // NOTE: the line buffer is flops, not SRAM, so it is cleared with the rest of the context.
            line_q      <= '0;
            hit_way_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_dirty_q  <= 1'b0;
            wr_shared_q <= 1'b0;
            inv_q       <= 1'b0;
            beat_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                S_IDLE: if (ac_valid_i) begin
                    addr_q    <= ac_addr_i;
                    snoop_q   <= ac_snoop_i;
                    resp_q    <= {3'b000, ~ac_supported, 1'b0};
                    hit_way_q <= '0;
                    inv_q     <= 1'b0;
                end
                S_EVAL: begin
                    resp_q      <= ev_resp;
                    hit_way_q   <= sel_way;
                    line_q      <= sel_line;
                    inv_q       <= ev_inv;
                    wr_valid_q  <= ~ev_inv;
                    wr_dirty_q  <= 1'b0;
                    wr_shared_q <= ~ev_inv & ev_shared;
                end
                S_CR: if (cr_ready_i) beat_q <= '0;
                S_CD: if (cd_ready_i) beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
                default: ;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign cr_resp_o   = resp_q;
    assign cd_data_o   = (state_q == S_CD) ? line_q[beat_q] : '0;
    assign cd_last_o   = (state_q == S_CD) && (beat_q == LAST_BEAT);
    assign addr_o      = addr_q[INDEX_W-1:0];
    assign tag_o       = addr_q[ADDR_W-1:INDEX_W];
    assign wr_valid_o  = wr_valid_q;
    assign wr_dirty_o  = wr_dirty_q;
    assign wr_shared_o = wr_shared_q;
    assign inv_addr_o  = addr_q;

endmodule

// File: tb/tb_snoop_cache_ctrl_mb.sv
// Bench for snoop_cache_ctrl_mb: a 2-beat instance (LINE_W=128) and a 4-beat
// instance (LINE_W=256) share stimulus; a scoreboard of expected CR responses,
// state writes and CD beats is filled when each snoop is issued.
module tb_snoop_cache_ctrl_mb;
    localparam int NW = 4, IW = 12, TW = 44, AW = IW + TW, LW = 128, LW4 = 256, CW = 64;

    typedef struct packed {
        logic          ac_ready, busy, cr_valid;
        logic [4:0]    cr_resp;
        logic          cd_valid;
        logic [CW-1:0] cd_data;
        logic          cd_last;
        logic [NW-1:0] req;
        logic [IW-1:0] addr;
        logic [TW-1:0] tag;
        logic          we;
        logic [NW-1:0] be;
        logic          wv, wd, ws, inv;
        logic [AW-1:0] inv_addr;
    } dut_out_t;

    typedef struct { logic [NW-1:0] be; logic v, d, s; } wr_t;

    logic clk = 1'b0, rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic               bypass, ac_valid, sel, gnt, cr_ready, cd_ready;
    logic [AW-1:0]      ac_addr;
    logic [3:0]         ac_snoop;
    logic [NW-1:0]      hit_way, dirty_way, shared_way;
    logic [NW*LW-1:0]   data_a;
    logic [NW*LW4-1:0]  data_b;
    wire dut_out_t      oa, ob;
    dut_out_t           o;
    assign o = sel ? ob : oa;

    logic [4:0]  q_cr[$];
    logic [CW:0] q_cd[$];
    wr_t         q_wr[$];
    int n_checks = 0, n_pass = 0;

    snoop_cache_ctrl_mb #(.NR_WAYS(NW), .INDEX_W(IW), .TAG_W(TW), .LINE_W(LW), .CD_W(CW)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .bypass_i(bypass), .busy_o(oa.busy),
        .ac_valid_i(ac_valid & ~sel), .ac_ready_o(oa.ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
        .cr_valid_o(oa.cr_valid), .cr_ready_i(cr_ready & ~sel), .cr_resp_o(oa.cr_resp),
        .cd_valid_o(oa.cd_valid), .cd_ready_i(cd_ready & ~sel), .cd_data_o(oa.cd_data), .cd_last_o(oa.cd_last),
        .req_o(oa.req), .addr_o(oa.addr), .tag_o(oa.tag), .gnt_i(gnt), .we_o(oa.we), .vldrty_be_o(oa.be),
        .wr_valid_o(oa.wv), .wr_dirty_o(oa.wd), .wr_shared_o(oa.ws), .data_i(data_a),
        .hit_way_i(hit_way), .dirty_way_i(dirty_way), .shared_way_i(shared_way),
        .inv_o(oa.inv), .inv_addr_o(oa.inv_addr));

    snoop_cache_ctrl_mb #(.NR_WAYS(NW), .INDEX_W(IW), .TAG_W(TW), .LINE_W(LW4), .CD_W(CW)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .bypass_i(bypass), .busy_o(ob.busy),
        .ac_valid_i(ac_valid & sel), .ac_ready_o(ob.ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
        .cr_valid_o(ob.cr_valid), .cr_ready_i(cr_ready & sel), .cr_resp_o(ob.cr_resp),
        .cd_valid_o(ob.cd_valid), .cd_ready_i(cd_ready & sel), .cd_data_o(ob.cd_data), .cd_last_o(ob.cd_last),
        .req_o(ob.req), .addr_o(ob.addr), .tag_o(ob.tag), .gnt_i(gnt), .we_o(ob.we), .vldrty_be_o(ob.be),
        .wr_valid_o(ob.wv), .wr_dirty_o(ob.wd), .wr_shared_o(ob.ws), .data_i(data_b),
        .hit_way_i(hit_way), .dirty_way_i(dirty_way), .shared_way_i(shared_way),
        .inv_o(ob.inv), .inv_addr_o(ob.inv_addr));

    function automatic int lowest(input logic [NW-1:0] h);
        for (int w = 0; w < NW; w++) if (h[w]) return w;
        return -1;
    endfunction

    function automatic bit supported(input logic [3:0] c);
        return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101};
    endfunction

    // Reference action table for a hit on a line with the given dirty/shared flags.
    function automatic void model(input logic [3:0] c, input logic d, input logic s,
                                  output logic [4:0] resp, output logic upd, output wr_t wr);
        logic dt, pd, is, inv;
        dt = 0; pd = 0; is = 0; upd = 0; inv = 0;
        case (c)
            4'b0000:                   begin dt = 1; is = 1; end
            4'b0001, 4'b0010, 4'b0011: begin dt = 1; pd = d; is = 1; upd = 1; end
            4'b0111:                   begin dt = 1; pd = d; upd = 1; inv = 1; end
            4'b1000:                   begin dt = d; pd = d; is = 1; upd = d; end
            4'b1001:                   begin dt = d; pd = d; upd = 1; inv = 1; end
            4'b1101:                   begin upd = 1; inv = 1; end
            default: ;
        endcase
        resp = {~s, is, pd, 1'b0, dt};
        wr.be = '0;
        wr.v  = ~inv;
        wr.d  = 1'b0;
        wr.s  = inv ? 1'b0 : ((c == 4'b1000) ? s : 1'b1);
    endfunction

    task automatic push_expect(input logic [3:0] code, output int n_inv);
        logic [4:0]     resp;
        logic           upd;
        wr_t            wr;
        logic [LW4-1:0] line;
        int way, nb;
        way = lowest(hit_way);
        upd = 0; n_inv = 0; wr = '{default: '0};
        if (!supported(code))          resp = 5'b00010;
        else if (bypass || way < 0)    resp = 5'b00000;
        else begin
            model(code, dirty_way[way], shared_way[way], resp, upd, wr);
            wr.be = NW'(1) << way;
        end
        q_cr.push_back(resp);
        if (upd) begin
            q_wr.push_back(wr);
            n_inv = wr.v ? 0 : 1;
        end
        if (resp[0]) begin
            nb   = sel ? LW4 / CW : LW / CW;
            line = sel ? data_b[way*LW4 +: LW4] : {{(LW4-LW){1'b0}}, data_a[way*LW +: LW]};
            for (int k = 0; k < nb; k++) q_cd.push_back({k == nb - 1, line[k*CW +: CW]});
        end
    endtask

    task automatic fill_data();
        for (int i = 0; i < NW * LW / 32; i++)  data_a[i*32 +: 32] = $urandom;
        for (int i = 0; i < NW * LW4 / 32; i++) data_b[i*32 +: 32] = $urandom;
    endtask

    // Issue one snoop (called on a negedge), act as SRAM arbiter and CR/CD sink
    // with the given stall counts, and compare every event against the scoreboard.
    task automatic run(input logic [3:0] code, input logic [AW-1:0] addr,
                       input int gs, input int rs, input int cs, output int cr_lat);
        int  gc, rc, cc, inv_seen, exp_inv;
        bit  done;
        wr_t w;
        logic [4:0]  er;
        logic [CW:0] ed;
        q_cr.delete(); q_cd.delete(); q_wr.delete();
        push_expect(code, exp_inv);
        gc = 0; rc = 0; cc = 0; inv_seen = 0; done = 0; cr_lat = -1;
        n_checks++;
        if (o.ac_ready !== 1'b1) $display("FAIL ac_ready_idle: got %b want 1", o.ac_ready); else n_pass++;
        ac_valid = 1; ac_addr = addr; ac_snoop = code;
        for (int it = 1; it <= 80 && !done; it++) begin
            @(negedge clk);
            ac_valid = 0; gnt = 0; cr_ready = 0; cd_ready = 0;
            n_checks++;
            if (o.ac_ready !== ~o.busy) $display("FAIL ac_ready_busy: ready %b busy %b", o.ac_ready, o.busy);
            else n_pass++;
            if (o.req != '0) begin
                if (gc < gs) gc++;
                else begin
                    gnt = 1; gc = 0;
                    if (o.we) begin
                        n_checks++;
                        if (q_wr.size() == 0) $display("FAIL unexpected_write: be %b", o.be);
                        else begin
                            w = q_wr.pop_front();
                            if ({o.req, o.be, o.wv, o.wd, o.ws} !== {w.be, w.be, w.v, w.d, w.s})
                                $display("FAIL state_write: got req %b be %b vds %b%b%b want be %b vds %b%b%b",
                                         o.req, o.be, o.wv, o.wd, o.ws, w.be, w.v, w.d, w.s);
                            else n_pass++;
                        end
                    end else begin
                        n_checks++;
                        if ({o.req, o.addr, o.tag} !== {{NW{1'b1}}, addr[IW-1:0], addr[AW-1:IW]})
                            $display("FAIL lookup_req: got req %b idx %h tag %h want idx %h tag %h",
                                     o.req, o.addr, o.tag, addr[IW-1:0], addr[AW-1:IW]);
                        else n_pass++;
                    end
                end
            end
            if (o.cr_valid) begin
                if (cr_lat < 0) cr_lat = it;
                n_checks++;
                if (q_cr.size() == 0) $display("FAIL unexpected_cr: resp %b", o.cr_resp);
                else begin
                    er = q_cr[0];
                    if (rc < rs) rc++;
                    else begin cr_ready = 1; rc = 0; void'(q_cr.pop_front()); done = (q_cd.size() == 0); end
                    if (o.cr_resp !== er) $display("FAIL cr_resp: got %b want %b", o.cr_resp, er);
                    else n_pass++;
                end
            end
            if (o.cd_valid) begin
                n_checks++;
                if (q_cd.size() == 0) $display("FAIL unexpected_cd: data %h", o.cd_data);
                else begin
                    ed = q_cd[0];
                    if (cc < cs) cc++;
                    else begin cd_ready = 1; cc = 0; void'(q_cd.pop_front()); done = (q_cd.size() == 0); end
                    if ({o.cd_last, o.cd_data} !== ed)
                        $display("FAIL cd_beat: got last %b data %h want last %b data %h",
                                 o.cd_last, o.cd_data, ed[CW], ed[CW-1:0]);
                    else n_pass++;
                end
            end
            #1;
            if (o.inv) begin
                inv_seen++;
                n_checks++;
                if (o.inv_addr !== addr) $display("FAIL inv_addr: got %h want %h", o.inv_addr, addr);
                else n_pass++;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL timeout: snoop %b not completed, %0d cr %0d cd left", code, q_cr.size(), q_cd.size());
        end
        @(negedge clk);
        cr_ready = 0; cd_ready = 0; gnt = 0;
        n_checks++;
        if ({o.busy, o.cd_valid, o.cr_valid} !== 3'b000)
            $display("FAIL return_idle: busy %b cd %b cr %b want 000", o.busy, o.cd_valid, o.cr_valid);
        else n_pass++;
        n_checks++;
        if (inv_seen !== exp_inv || q_wr.size() != 0)
            $display("FAIL inv_count: got %0d want %0d, missing writes %0d", inv_seen, exp_inv, q_wr.size());
        else n_pass++;
    endtask

    task automatic set_line(input logic [NW-1:0] h, input logic [NW-1:0] d, input logic [NW-1:0] s);
        hit_way = h; dirty_way = d; shared_way = s;
    endtask

    task automatic test_reset();
        dut_out_t e;
        e = '0; e.ac_ready = 1'b1;
        rst_ni = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (oa !== e) $display("FAIL reset_a: got %h want %h", oa, e); else n_pass++;
        n_checks++;
        if (ob !== e) $display("FAIL reset_b: got %h want %h", ob, e); else n_pass++;
        rst_ni = 1;
        @(negedge clk);
    endtask

    task automatic test_rd_shared();
        int lat;
        sel = 0; fill_data();
        set_line(4'b0100, 4'b0100, 4'b0100);
        run(4'b0001, {$urandom, $urandom}, 0, 0, 0, lat);
        set_line(4'b0110, 4'b0100, 4'b0000);
        run(4'b0001, {$urandom, $urandom}, 0, 0, 0, lat);
    endtask

    task automatic test_rd_unique();
        int lat;
        fill_data();
        set_line(4'b1010, 4'b0000, 4'b0000);
        run(4'b0111, {$urandom, $urandom}, 0, 0, 0, lat);
    endtask

    task automatic test_clean_invalid();
        int lat;
        set_line(4'b0001, 4'b0000, 4'b0000);
        run(4'b1001, {$urandom, $urandom}, 0, 0, 0, lat);
        set_line(4'b0001, 4'b0001, 4'b0000);
        run(4'b1001, {$urandom, $urandom}, 0, 0, 0, lat);
    endtask

    task automatic test_miss_bypass();
        logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101};
        int lat;
        set_line(4'b0000, 4'b1111, 4'b0000);
        foreach (codes[i]) begin
            run(codes[i], {$urandom, $urandom}, 0, 0, 0, lat);
            n_checks++;
            if (lat < 1 || lat > 4) $display("FAIL miss_latency: got %0d want 1..4", lat); else n_pass++;
        end
        set_line(4'b1111, 4'b1111, 4'b0000);
        run(4'b0101, {$urandom, $urandom}, 0, 0, 0, lat);
        bypass = 1;
        run(4'b0111, {$urandom, $urandom}, 0, 0, 0, lat);
        n_checks++;
        if (lat < 1 || lat > 2) $display("FAIL bypass_latency: got %0d want 1..2", lat); else n_pass++;
        bypass = 0;
    endtask

    task automatic test_other_codes();
        logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1101};
        int lat;
        for (int i = 0; i < 12; i++) begin
            fill_data();
            set_line(NW'($urandom_range(1, 15)), NW'($urandom), NW'($urandom));
            run(codes[$urandom_range(0, 7)], {$urandom, $urandom}, $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2), lat);
        end
    endtask

    task automatic test_stall();
        int lat;
        fill_data();
        set_line(4'b0100, 4'b0100, 4'b0100);
        run(4'b0001, {$urandom, $urandom}, 3, 3, 3, lat);
        set_line(4'b0011, 4'b0001, 4'b0000);
        run(4'b1001, {$urandom, $urandom}, 3, 3, 3, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        set_line(4'b0010, 4'b0010, 4'b0000);
        run(4'b1000, {$urandom, $urandom}, 0, 0, 0, lat);
        run(4'b0000, {$urandom, $urandom}, 0, 0, 0, lat);
        set_line(4'b1000, 4'b0000, 4'b1000);
        run(4'b1101, {$urandom, $urandom}, 0, 0, 0, lat);
    endtask

    task automatic test_four_beats();
        int lat;
        sel = 1; fill_data();
        set_line(4'b1000, 4'b0000, 4'b1000);
        run(4'b0000, {$urandom, $urandom}, 0, 0, 1, lat);
        set_line(4'b0101, 4'b0001, 4'b0000);
        run(4'b0011, {$urandom, $urandom}, 1, 2, 2, lat);
    endtask

    task automatic test_reset_in_cd();
        sel = 1;
        set_line(4'b0010, 4'b0000, 4'b0000);
        ac_valid = 1; ac_snoop = 4'b0000; ac_addr = {$urandom, $urandom};
        @(negedge clk); ac_valid = 0; gnt = 1;
        @(negedge clk); gnt = 0;
        @(negedge clk);
        n_checks++;
        if (o.cr_valid !== 1'b1) $display("FAIL rst_cd_cr: got %b want 1", o.cr_valid); else n_pass++;
        cr_ready = 1;
        @(negedge clk); cr_ready = 0;
        n_checks++;
        if (o.cd_valid !== 1'b1) $display("FAIL rst_cd_enter: got %b want 1", o.cd_valid); else n_pass++;
        rst_ni = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({o.cd_valid, o.busy, o.ac_ready} !== 3'b001)
            $display("FAIL rst_cd_abort: cd %b busy %b ready %b want 001", o.cd_valid, o.busy, o.ac_ready);
        else n_pass++;
        @(negedge clk); rst_ni = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o.cr_valid, o.cd_valid, o.req, o.we} !== '0)
                $display("FAIL rst_cd_quiet: cr %b cd %b req %b we %b want 0", o.cr_valid, o.cd_valid, o.req, o.we);
            else n_pass++;
        end
    endtask

    initial begin
        bypass = 0; ac_valid = 0; sel = 0; gnt = 0; cr_ready = 0; cd_ready = 0;
        ac_addr = '0; ac_snoop = '0; hit_way = '0; dirty_way = '0; shared_way = '0;
        data_a = '0; data_b = '0;
        test_reset();
        test_rd_shared();
        test_rd_unique();
        test_clean_invalid();
        test_miss_bypass();
        test_other_codes();
        test_stall();
        test_back_to_back();
        test_four_beats();
        test_reset_in_cd();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
